// File: rtl/clk_div_multi.sv
// -----------------------------------------------------------------------------
// clk_div_multi
//
// Purpose:
//   N-channel clock divider / clock-enable generator. Each channel counts up to
//   a runtime-loadable terminal count D and then restarts, so it terminates
//   every D+1 enabled cycles. On each terminal count a channel raises a
//   one-cycle tick and, depending on its mode, either toggles clk_out (mode 0,
//   50% duty clock with period 2*(D+1)) or pulses clk_out for that one cycle
//   (mode 1, same as tick). A global sync re-aligns the phase of all channels.
//
// Ports:
//   CLK      in   1      board clock, all logic on the rising edge
//   RST      in   1      synchronous reset, active-high
//   en       in   NCH    per-channel run enable
//   load     in   NCH    per-channel divisor load strobe (works even when en=0)
//   div_in   in   CNT_W  terminal count D, shared by all channels
//   mode     in   NCH    per-channel mode: 0 = toggle, 1 = pulse
//   sync     in   1      clears every counter and output (a load still wins)
//   clk_out  out  NCH    per-channel divided output, registered
//   tick     out  NCH    per-channel one-cycle terminal-count strobe, registered
//
// Per-channel priority on every edge: RST > load > sync > en > hold.
// -----------------------------------------------------------------------------
module clk_div_multi #(
    parameter int              NCH         = 2,
    parameter int              CNT_W       = 26,
    parameter logic [CNT_W-1:0] DEFAULT_DIV = CNT_W'(24999999)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [NCH-1:0]   en,
    input  logic [NCH-1:0]   load,
    input  logic [CNT_W-1:0] div_in,
    input  logic [NCH-1:0]   mode,
    input  logic             sync,
    output logic [NCH-1:0]   clk_out,
    output logic [NCH-1:0]   tick
);

    logic [CNT_W-1:0] count_q [NCH];
    logic [CNT_W-1:0] count_d [NCH];
    logic [CNT_W-1:0] div_q   [NCH];
    logic [CNT_W-1:0] div_d   [NCH];
    logic [NCH-1:0]   clk_out_q;
    logic [NCH-1:0]   clk_out_d;
    logic [NCH-1:0]   tick_q;
    logic [NCH-1:0]   tick_d;

    // Next-state logic for every channel.
    always_comb begin
        // NOTE: every signal gets a hold/default value first so no path through
        // the if/else chain can leave it unassigned and infer a latch.
        clk_out_d = clk_out_q;
        tick_d    = '0;
        for (int i = 0; i < NCH; i++) begin
            count_d[i] = count_q[i];
            div_d[i]   = div_q[i];

            if (load[i]) begin
                // New divisor restarts the count; clk_out keeps its level so a
                // running toggle clock does not glitch on a reload.
                div_d[i]   = div_in;
                count_d[i] = '0;
            end else if (sync) begin
                count_d[i]   = '0;
                clk_out_d[i] = 1'b0;
            end else if (en[i]) begin
                if (count_q[i] == div_q[i]) begin
                    count_d[i]   = '0;
                    tick_d[i]    = 1'b1;
                    clk_out_d[i] = mode[i] ? 1'b1 : ~clk_out_q[i];
                end else begin
                    count_d[i] = count_q[i] + CNT_W'(1);
                    // Pulse mode drops clk_out on every non-terminal cycle; this
                    // also pulls it low right after a switch from toggle mode.
                    if (mode[i]) begin
                        clk_out_d[i] = 1'b0;
                    end
                end
            end
            // en=0: count and clk_out hold, tick already defaults to 0.
        end
    end

    // State registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            // NOTE: the divisor registers are control state, not a storage
            // array, so they are reset like any other flop to a known D.
            for (int i = 0; i < NCH; i++) begin
                count_q[i] <= '0;
                div_q[i]   <= DEFAULT_DIV;
            end
            clk_out_q <= '0;
            tick_q    <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the values
            // from before this edge, independent of statement order.
            for (int i = 0; i < NCH; i++) begin
                count_q[i] <= count_d[i];
                div_q[i]   <= div_d[i];
            end
            clk_out_q <= clk_out_d;
            tick_q    <= tick_d;
        end
    end

    assign clk_out = clk_out_q;
    assign tick    = tick_q;

endmodule

// File: tb/tb_clk_div_multi.sv
// -----------------------------------------------------------------------------
// tb_clk_div_multi
//
// Directed bench for clk_div_multi with two channels and a small reset divisor
// (DEFAULT_DIV = 9) so the reset value of the divisor is observable as a first
// tick on the 10th enabled edge. Inputs change 1 time unit after a rising edge,
// outputs are sampled at the same point, i.e. they reflect the edge just taken.
// -----------------------------------------------------------------------------
module tb_clk_div_multi;

    localparam int NCH   = 2;
    localparam int CNT_W = 26;

    logic             CLK;
    logic             RST;
    logic [NCH-1:0]   en;
    logic [NCH-1:0]   load;
    logic [CNT_W-1:0] div_in;
    logic [NCH-1:0]   mode;
    logic             sync;
    logic [NCH-1:0]   clk_out;
    logic [NCH-1:0]   tick;

    int n_checks = 0;
    int n_fail   = 0;

    clk_div_multi #(
        .NCH         (NCH),
        .CNT_W       (CNT_W),
        .DEFAULT_DIV (CNT_W'(9))
    ) dut (
        .CLK     (CLK),
        .RST     (RST),
        .en      (en),
        .load    (load),
        .div_in  (div_in),
        .mode    (mode),
        .sync    (sync),
        .clk_out (clk_out),
        .tick    (tick)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        RST    = 1'b1;
        en     = '0;
        load   = '0;
        div_in = '0;
        mode   = '0;
        sync   = 1'b0;
        step();
        step();
        check("rst_clk_out", 32'(clk_out), 32'h0);
        check("rst_tick",    32'(tick),    32'h0);

        // Reset divisor D=9, ch0 pulse mode: first tick on the 10th edge.
        RST  = 1'b0;
        en   = 2'b01;
        mode = 2'b01;
        for (int k = 1; k <= 10; k++) begin
            step();
            check($sformatf("rstdiv_tick_k%0d", k), 32'(tick[0]), 32'(k == 10));
        end

        // Test 1: ch0 pulse mode, D=3. Load holds clk_out (1 from last tick).
        div_in = 3;
        load   = 2'b01;
        step();
        load = '0;
        check("t1_load_clk_hold", 32'(clk_out[0]), 32'h1);
        check("t1_load_tick",     32'(tick[0]),    32'h0);
        for (int k = 1; k <= 8; k++) begin
            step();
            check($sformatf("t1_tick_k%0d", k), 32'(tick[0]),    32'(k % 4 == 0));
            check($sformatf("t1_clk_k%0d", k),  32'(clk_out[0]), 32'(k % 4 == 0));
        end

        // Test 2: ch1 toggle mode, D=3: 4 high, 4 low, tick on each toggle.
        div_in = 3;
        load   = 2'b10;
        mode   = 2'b01;
        en     = 2'b11;
        step();
        load = '0;
        for (int k = 1; k <= 16; k++) begin
            step();
            check($sformatf("t2_tick_k%0d", k), 32'(tick[1]),    32'(k % 4 == 0));
            check($sformatf("t2_clk_k%0d", k),  32'(clk_out[1]), 32'((k / 4) % 2));
        end

        // Test 3: D=0 on both; ch0 pulse (held at 1), ch1 toggle (CLK/2).
        div_in = 0;
        load   = 2'b11;
        step();
        load = '0;
        for (int k = 1; k <= 4; k++) begin
            step();
            check($sformatf("t3_tick_k%0d", k), 32'(tick),       32'h3);
            check($sformatf("t3_clk0_k%0d", k), 32'(clk_out[0]), 32'h1);
            check($sformatf("t3_clk1_k%0d", k), 32'(clk_out[1]), 32'(k % 2));
        end

        // Test 4: ch0 toggle, D=5, freeze at count=2 for 5 cycles.
        div_in = 5;
        load   = 2'b01;
        mode   = 2'b00;
        step();
        load = '0;
        step();
        step();
        en[0] = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            step();
            check($sformatf("t4_frz_tick_k%0d", k), 32'(tick[0]),    32'h0);
            check($sformatf("t4_frz_clk_k%0d", k),  32'(clk_out[0]), 32'h1);
        end
        en[0] = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            step();
            check($sformatf("t4_run_tick_k%0d", k), 32'(tick[0]),    32'(k == 4));
            check($sformatf("t4_run_clk_k%0d", k),  32'(clk_out[0]), 32'(k != 4));
        end

        // Test 5: ch0 D=2, ch1 D=6 toggle; sync, then both tick together at 21.
        div_in = 2;
        load   = 2'b01;
        step();
        div_in = 6;
        load   = 2'b10;
        step();
        load = '0;
        for (int k = 0; k < 5; k++) step();
        sync = 1'b1;
        step();
        sync = 1'b0;
        check("t5_sync_clk",  32'(clk_out), 32'h0);
        check("t5_sync_tick", 32'(tick),    32'h0);
        for (int k = 1; k <= 21; k++) begin
            step();
            check($sformatf("t5_tick_k%0d", k), 32'(tick),
                  32'({k % 7 == 0, k % 3 == 0}));
            check($sformatf("t5_clk_k%0d", k), 32'(clk_out),
                  32'({(k / 7) % 2 == 1, (k / 3) % 2 == 1}));
        end

        // Test 6a: load ch0 and sync together; load wins on ch0 (clk holds 1).
        div_in = 4;
        load   = 2'b01;
        sync   = 1'b1;
        step();
        load = '0;
        sync = 1'b0;
        check("t6_ldsync_clk",  32'(clk_out), 32'h1);
        check("t6_ldsync_tick", 32'(tick),    32'h0);
        for (int k = 1; k <= 5; k++) begin
            step();
            check($sformatf("t6_tick_k%0d", k), 32'(tick),    32'(k == 5 ? 1 : 0));
            check($sformatf("t6_clk_k%0d", k),  32'(clk_out), 32'(k == 5 ? 0 : 1));
        end

        // Test 6b: reset mid-period restores outputs and D=9 on both channels.
        RST = 1'b1;
        step();
        check("t6_rst_clk",  32'(clk_out), 32'h0);
        check("t6_rst_tick", 32'(tick),    32'h0);
        RST  = 1'b0;
        mode = 2'b11;
        en   = 2'b11;
        for (int k = 1; k <= 10; k++) begin
            step();
            check($sformatf("t6_rstdiv_tick_k%0d", k), 32'(tick), 32'(k == 10 ? 3 : 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
